// File: rtl/multi_port_grf.sv
// Multi-port register file with per-register pending-write counters.
// Optional same-cycle write-to-read forwarding when GRF_BYPASS_EN is defined.
module multi_port_grf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              Busy1,
    output logic              Busy2,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA0,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [DATA_W-1:0] WD0,
    input  logic [DATA_W-1:0] WD1,
    input  logic              IssueEn,
    input  logic [ADDR_W-1:0] IssueA,
    output logic              IssueStall,
    output logic              Err
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
    logic              err_q;
    logic              err_d;

    logic we0_v;
    logic we1_v;
    logic issue_req;
    logic issue_ok;

    // Inputs are ignored entirely while reset is held.
    assign we0_v     = Reset_n & WE0 & (WA0 != '0);
    assign we1_v     = Reset_n & WE1 & (WA1 != '0);
    assign issue_req = Reset_n & IssueEn & (IssueA != '0);
    assign IssueStall = issue_req & (&cnt_q[IssueA]);
    assign issue_ok   = issue_req & ~(&cnt_q[IssueA]);
    assign Err        = err_q;

    always_comb begin
        int sum;
        sum      = 0;
        err_d    = err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            sum = int'(cnt_q[r]);
            if (issue_ok && IssueA == ADDR_W'(r))
                sum = sum + 1;
            if (we0_v && WA0 == ADDR_W'(r))
                sum = sum - 1;
            if (we1_v && WA1 == ADDR_W'(r))
                sum = sum - 1;
            if (sum < 0) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
                // Port 1 is the older writer, so it wins a collision.
                if (we1_v && WA1 == ADDR_W'(r))
                    regs_q[r] <= WD1;
                else if (we0_v && WA0 == ADDR_W'(r))
                    regs_q[r] <= WD0;
            end
        end
    end

`ifdef GRF_BYPASS_EN
    function automatic logic [DATA_W-1:0] rd_port(
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] v;
        v = regs_q[a];
        if (a != '0) begin
            if (we1_v && WA1 == a)
                v = WD1;
            else if (we0_v && WA0 == a)
                v = WD0;
        end
        return v;
    endfunction

    assign RD1   = rd_port(A1);
    assign RD2   = rd_port(A2);
    assign Busy1 = Reset_n & (cnt_d[A1] != '0);
    assign Busy2 = Reset_n & (cnt_d[A2] != '0);
`else
    assign RD1   = regs_q[A1];
    assign RD2   = regs_q[A2];
    assign Busy1 = cnt_q[A1] != '0;
    assign Busy2 = cnt_q[A2] != '0;
`endif

endmodule

// File: tb/tb_multi_port_grf.sv
// Directed vector bench for multi_port_grf (default and GRF_BYPASS_EN builds).
module tb_multi_port_grf;

`ifdef GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk;
    logic        Reset_n;
    logic [4:0]  A1, A2, WA0, WA1, IssueA;
    logic [31:0] RD1, RD2, WD0, WD1;
    logic        Busy1, Busy2, WE0, WE1, IssueEn, IssueStall, Err;

    int checks = 0;
    int errors = 0;

    multi_port_grf dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
        .Busy1(Busy1), .Busy2(Busy2),
        .WE0(WE0), .WE1(WE1), .WA0(WA0), .WA1(WA1),
        .WD0(WD0), .WD1(WD1),
        .IssueEn(IssueEn), .IssueA(IssueA),
        .IssueStall(IssueStall), .Err(Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        ien;
        logic [4:0]  ia;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        st;
        logic        err;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string n, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", n, i, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        WE0 = v.we0; WA0 = v.wa0; WD0 = v.wd0;
        WE1 = v.we1; WA1 = v.wa1; WD1 = v.wd1;
        A1 = v.a1; A2 = v.a2;
        IssueEn = v.ien; IssueA = v.ia;
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        WE0 = 0; WA0 = 0; WD0 = 0;
        WE1 = 0; WA1 = 0; WD1 = 0;
        IssueEn = 0; IssueA = 0;
        A1 = a1; A2 = a2;
    endtask

    initial begin
        // we0 wa0 wd0 | we1 wa1 wd1 | a1 a2 | ien ia | rd1 rd2 b1 b2 st err
        // Reads never target a register written or issued in the same
        // cycle, so these expectations hold with or without forwarding.
        tbl[0]  = '{0, 0, 0,       0, 0, 0,     0, 0,  0, 0, 0,       0,       0, 0, 0, 0};
        tbl[1]  = '{1, 5, 'h1234,  0, 0, 0,     0, 0,  0, 0, 0,       0,       0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0,       0, 0, 0,     5, 0,  0, 0, 'h1234,  0,       0, 0, 0, 1};
        tbl[3]  = '{1, 0, 'hFFFF,  0, 0, 0,     5, 0,  0, 0, 'h1234,  0,       0, 0, 0, 1};
        tbl[4]  = '{0, 0, 0,       0, 0, 0,     0, 5,  0, 0, 0,       'h1234,  0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 3, 0,       0,       0, 0, 0, 1};
        tbl[6]  = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 3, 0,       0,       0, 0, 0, 1};
        tbl[7]  = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 3, 0,       0,       0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 3, 0,       0,       0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0,       0, 0, 0,     3, 0,  0, 0, 0,       0,       1, 0, 0, 1};
        tbl[10] = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 3, 0,       0,       0, 0, 1, 1};
        tbl[11] = '{1, 3, 'h11,    0, 0, 0,     0, 0,  0, 0, 0,       0,       0, 0, 0, 1};
        tbl[12] = '{0, 0, 0,       1, 3, 'h22,  0, 0,  0, 0, 0,       0,       0, 0, 0, 1};
        tbl[13] = '{0, 0, 0,       0, 0, 0,     3, 0,  0, 0, 'h22,    0,       1, 0, 0, 1};
        tbl[14] = '{1, 3, 'h33,    0, 0, 0,     0, 0,  0, 0, 0,       0,       0, 0, 0, 1};
        tbl[15] = '{0, 0, 0,       0, 0, 0,     3, 3,  0, 0, 'h33,    'h33,    0, 0, 0, 1};
        tbl[16] = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 4, 0,       0,       0, 0, 0, 1};
        tbl[17] = '{0, 0, 0,       0, 0, 0,     0, 4,  0, 0, 0,       0,       0, 1, 0, 1};
        tbl[18] = '{1, 4, 'h44,    0, 0, 0,     0, 0,  1, 4, 0,       0,       0, 0, 0, 1};
        tbl[19] = '{0, 0, 0,       0, 0, 0,     0, 4,  0, 0, 0,       'h44,    0, 1, 0, 1};
        tbl[20] = '{0, 0, 0,       0, 0, 0,     0, 0,  1, 0, 0,       0,       0, 0, 0, 1};
        tbl[21] = '{1, 10, 'hA0,   1, 11, 'hB1, 0, 0,  0, 0, 0,       0,       0, 0, 0, 1};
        tbl[22] = '{0, 0, 0,       0, 0, 0,     10, 11, 0, 0, 'hA0,   'hB1,    0, 0, 0, 1};

        Reset_n = 1'b0;
        idle(0, 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(posedge Clk);
            #1 apply(tbl[i]);
            @(negedge Clk);
            chk("rd1", i, RD1, tbl[i].rd1);
            chk("rd2", i, RD2, tbl[i].rd2);
            chk("busy1", i, 32'(Busy1), 32'(tbl[i].b1));
            chk("busy2", i, 32'(Busy2), 32'(tbl[i].b2));
            chk("stall", i, 32'(IssueStall), 32'(tbl[i].st));
            chk("err", i, 32'(Err), 32'(tbl[i].err));
        end

        // Asynchronous reset mid-operation: reg4 still has a pending count.
        @(posedge Clk);
        #1 idle(0, 4);
        #2 chk("pre_rst_busy2", 0, 32'(Busy2), 1);
        #1 Reset_n = 1'b0;
        #1;
        chk("rst_err", 0, 32'(Err), 0);
        chk("rst_busy2", 0, 32'(Busy2), 0);
        chk("rst_rd2", 0, RD2, 0);
        WE0 = 1; WA0 = 9; WD0 = 'h99;
        IssueEn = 1; IssueA = 9; A1 = 9;
        @(posedge Clk);
        #1 chk("rst_stall", 0, 32'(IssueStall), 0);
        chk("rst_rd1", 0, RD1, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        idle(9, 4);
        @(negedge Clk);
        chk("rel_rd1", 0, RD1, 0);
        chk("rel_busy1", 0, 32'(Busy1), 0);
        chk("rel_err", 0, 32'(Err), 0);

        // Writeback to register 9 with no pending count sets sticky Err.
        @(posedge Clk);
        #1 begin WE0 = 1; WA0 = 9; WD0 = 'h9; end
        @(negedge Clk);
        chk("err9_pre", 0, 32'(Err), 0);
        @(posedge Clk);
        #1 idle(9, 0);
        @(negedge Clk);
        chk("err9_set", 0, 32'(Err), 1);
        chk("err9_rd1", 0, RD1, 'h9);
        repeat (2) @(negedge Clk);
        chk("err9_sticky", 0, 32'(Err), 1);

        // Reset pulse strictly between edges.
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1 chk("pulse_err", 0, 32'(Err), 0);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        chk("pulse_err2", 0, 32'(Err), 0);
        chk("pulse_rd1", 0, RD1, 0);

        // Colliding writes to reg 7 with count 1: WD1 stored, clamp, Err.
        @(posedge Clk);
        #1 begin idle(0, 0); IssueEn = 1; IssueA = 7; end
        @(posedge Clk);
        #1 begin
            idle(0, 0);
            WE0 = 1; WA0 = 7; WD0 = 'hAAAA;
            WE1 = 1; WA1 = 7; WD1 = 'h5555;
        end
        @(negedge Clk);
        chk("col_err_pre", 0, 32'(Err), 0);
        @(posedge Clk);
        #1 idle(7, 0);
        @(negedge Clk);
        chk("col_rd1", 0, RD1, 'h5555);
        chk("col_busy1", 0, 32'(Busy1), 0);
        chk("col_err", 0, 32'(Err), 1);

        // Forwarding visibility on read port 2.
        @(posedge Clk);
        #1 begin idle(0, 0); WE0 = 1; WA0 = 6; WD0 = 'h600D; end
        @(posedge Clk);
        #1 begin idle(0, 0); IssueEn = 1; IssueA = 6; end
        @(posedge Clk);
        #1 begin idle(0, 6); WE1 = 1; WA1 = 6; WD1 = 'hBEEF; end
        @(negedge Clk);
        chk("byp_rd2", 0, RD2, BYP ? 32'hBEEF : 32'h600D);
        chk("byp_busy2", 0, 32'(Busy2), BYP ? 0 : 1);
        @(posedge Clk);
        #1 idle(0, 6);
        @(negedge Clk);
        chk("post_rd2", 0, RD2, 'hBEEF);
        chk("post_busy2", 0, 32'(Busy2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_port_grf.md
MULTI_PORT_GRF -- requirements
Module: multi_port_grf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width; NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have parameter CNT_W, default 2, width of each register's pending-write counter.
REQ-004 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports A1, A2  input  ADDR_W  read addresses.
REQ-007 SHALL have ports RD1, RD2  output  DATA_W  read data.
REQ-008 SHALL have ports Busy1, Busy2  output  1  pending-write flag for A1 and A2.
REQ-009 SHALL have ports WE0, WE1  input  1  write enables; port 1 is the older, later-stage writer.
REQ-010 SHALL have ports WA0, WA1  input  ADDR_W  write addresses.
REQ-011 SHALL have ports WD0, WD1  input  DATA_W  write data.
REQ-012 SHALL have port IssueEn  input  1  a new producer of register IssueA enters the pipeline.
REQ-013 SHALL have port IssueA  input  ADDR_W  destination register of the issue.
REQ-014 SHALL have port IssueStall  output  1  issue refused, IssueA counter saturated.
REQ-015 SHALL have port Err  output  1  sticky error, writeback to a register with zero count.

Function
REQ-016 SHALL hold NUM_REGS x DATA_W registers; register 0 always reads 0, is never written, and its counter stays 0.
REQ-017 SHALL read RD1/RD2 combinationally from the array (zero latency).
REQ-018 SHALL write WDn to register WAn on the rising edge when WEn=1 and WAn!=0.
REQ-019 SHALL, when WE0=WE1=1 and WA0=WA1!=0, store WD1.
REQ-020 SHALL keep one CNT_W-bit counter per register; Busy1/Busy2 = (counter[A1/A2] != 0).
REQ-021 SHALL combinationally assert IssueStall when IssueEn=1, IssueA!=0 and counter[IssueA] is all-ones.
REQ-022 SHALL, per edge, compute each counter's next value as count + accepted_issue - (WE0 & WA0 match) - (WE1 & WA1 match); an accepted issue has IssueEn=1, IssueA!=0 and IssueStall=0.
REQ-023 SHALL apply a same-cycle issue and writeback to one register as net zero, leaving Busy unchanged.
REQ-024 SHALL, if a decrement would take a counter below 0, clamp it to 0 and set Err=1; Err holds until reset.
REQ-025 SHALL ignore an issue to register 0 and never stall it.
REQ-026 SHALL treat every write as a writeback that decrements its counter, including a write whose data is dropped by the collision rule in REQ-019.

Reset
REQ-027 SHALL, on Reset_n=0 and without waiting for Clk, clear all registers, all counters and Err; RD1=RD2=0, Busy1=Busy2=0 and IssueStall=0 while reset is held.
REQ-028 SHALL ignore writes and issues while Reset_n=0; on release, the first state update is on the next rising edge.
REQ-029 SHALL, on reset assertion mid-operation, discard every pending count and every in-flight write.

Configuration
REQ-030 SHALL, when macro GRF_BYPASS_EN is defined, forward write data to a read port: when An matches an enabled write address and An!=0, RDn shows that write's data, WD1 taking priority over WD0, and Busyn reads the post-edge counter value.
REQ-031 SHALL, when GRF_BYPASS_EN is undefined, return RDn from the stored array only, with Busy reflecting the current counter; the new value is visible the cycle after the write.

Verification
REQ-032 SHALL cover: reset, WE0=1, WA0=5, WD0=0x1234, then A1=5 -> RD1=0x1234 one cycle later; writing 0xFFFF to register 0 leaves RD1=0 at A1=0.
REQ-033 SHALL cover: WE0=WE1=1, WA0=WA1=7, WD0=0xAAAA, WD1=0x5555 -> register 7 holds 0x5555 and is left at counter 0, Err=1 when it started at counter 1.
REQ-034 SHALL cover: three issues to register 3 -> Busy=1 and fourth IssueEn shows IssueStall=1 with counter held at 3; three writebacks -> Busy1=0 at A1=3.
REQ-035 SHALL cover: counter[4]=1, IssueA=4 issue plus WE0 writeback to 4 in one cycle -> counter stays 1, Busy stays 1.
REQ-036 SHALL cover: writeback to register 9 with counter 0 -> Err=1 and stays set; Reset_n pulsed low between edges -> Err=0, all Busy=0 immediately.
REQ-037 SHALL cover, with GRF_BYPASS_EN defined: A2=6, WE1=1, WA1=6, WD1=0xBEEF -> RD2=0xBEEF in the same cycle; without the macro -> old value, then 0xBEEF the next cycle.
